// File: rtl/funct_encoder.sv
// funct_encoder: encodes an ALU select plus register fields into a MIPS R-type word.
// Latency: one cycle from an accepted request to instr/instr_valid. The output comes from the 2-entry FIFO head register.
// Backpressure: req_ready drops when the FIFO is full and the consumer is stalling (instr_ready=0).
//
// Ports:
//   clk, reset                  - single rising-edge clock, async active-high reset
//   req_valid / req_ready       - request handshake
//   select_bits_ALU[2:0]        - requested ALU op; 3'b011 is unsupported and rejected
//   rs, rt, rd, shamt [4:0]     - instruction fields
//   instr_valid / instr_ready   - output handshake, instr[31:0] is the encoded word
//   err_pulse                   - one-cycle flag after an unsupported request is consumed
//   err_count[ERR_CNT_W-1:0]    - saturating count of rejected requests
module funct_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           select_bits_ALU,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic [4:0]           rd,
  input  logic [4:0]           shamt,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                 state_q, state_d;
  logic [31:0]          head_q, head_d;
  logic [31:0]          tail_q, tail_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [5:0]  funct;
  logic        supported;
  logic [4:0]  shamt_eff;
  logic [31:0] word;
  logic        accept, push, pop;

  // Select-to-funct mapping.
  always_comb begin
    funct     = 6'b000000;
    supported = 1'b1;
    case (select_bits_ALU)
      3'b000:  funct = 6'b100100;  // and
      3'b001:  funct = 6'b100101;  // or
      3'b010:  funct = 6'b100000;  // add
      3'b100:  funct = 6'b100010;  // sub
      3'b101:  funct = 6'b000010;  // srl
      3'b110:  funct = 6'b000000;  // sll
      3'b111:  funct = 6'b100111;  // nor
      default: supported = 1'b0;   // 3'b011 has no encoding
    endcase
  end

  // Only the shift ops carry a shift amount; the field is zero otherwise.
  assign shamt_eff = ((funct == 6'b000000) || (funct == 6'b000010)) ? shamt : 5'd0;
  assign word      = {6'b000000, rs, rt, rd, shamt_eff, funct};

  // A full FIFO can still take a request when the head leaves this same cycle.
  assign req_ready = (state_q != FULL) || instr_ready;
  assign accept    = req_valid && req_ready;
  assign push      = accept && supported;
  assign pop       = (state_q != EMPTY) && instr_ready;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    err_pulse_d = accept && !supported;
    err_count_d = err_count_q;

    if (accept && !supported && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = word;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          tail_d  = word;
        end else if (push && pop) begin
          head_d = word;
        end else if (pop) begin
          state_d = EMPTY;
          head_d  = 32'd0;  // an empty FIFO presents an all-zero word
        end
      end
      FULL: begin
        // Without pop, req_ready is low, so push cannot occur here.
        if (pop && push) begin
          head_d = tail_q;
          tail_d = word;
        end else if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = 32'd0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = 32'd0;
        tail_d  = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_q      <= 32'd0;
      tail_q      <= 32'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign instr_valid = (state_q != EMPTY);
  assign instr       = head_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_funct_encoder.sv
// tb_funct_encoder: directed self-checking bench for funct_encoder.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked at the same point.
// Expected words are hand-assembled constants.
module tb_funct_encoder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  select_bits_ALU;
  logic [4:0]  rs, rt, rd, shamt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  funct_encoder #(.ERR_CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .select_bits_ALU (select_bits_ALU),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .shamt           (shamt),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .err_pulse       (err_pulse),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] sel, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] sh);
    req_valid       = 1'b1;
    select_bits_ALU = sel;
    rs              = a;
    rt              = b;
    rd              = c;
    shamt           = sh;
  endtask

  // Reference decode of funct into the ALU select.
  function automatic logic [2:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100000: return 3'b010;
      6'b100010: return 3'b100;
      6'b000010: return 3'b101;
      6'b000000: return 3'b110;
      6'b100111: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  logic [2:0] sels [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    reset = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
    select_bits_ALU = 3'b000; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0;
    #2;
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // add: rs=1 rt=2 rd=3 shamt=7 (shamt forced to 0)
    instr_ready = 1'b1;
    drive_req(3'b010, 5'd1, 5'd2, 5'd3, 5'd7);
    step();
    check("add_instr", instr, 32'h00221820);
    check("add_valid", {31'd0, instr_valid}, 32'd1);
    // sll, then srl back-to-back; shamt passes through
    drive_req(3'b110, 5'd0, 5'd4, 5'd5, 5'd3);
    step();
    check("sll_instr", instr, 32'h000428C0);
    drive_req(3'b101, 5'd0, 5'd4, 5'd5, 5'd3);
    step();
    check("srl_instr", instr, 32'h000428C2);
    req_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, instr_valid}, 32'd0);
    check("drain_instr", instr, 32'd0);

    // Backpressure: A, B fill the FIFO, and C is held off.
    instr_ready = 1'b0;
    drive_req(3'b000, 5'd1, 5'd2, 5'd3, 5'd9);       // A = 0x00221824
    step();
    check("bp_one_ready", {31'd0, req_ready}, 32'd1);
    check("bp_A_head", instr, 32'h00221824);
    drive_req(3'b001, 5'd4, 5'd5, 5'd6, 5'd0);       // B = 0x00853025
    step();
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    drive_req(3'b111, 5'd31, 5'd0, 5'd31, 5'd31);    // C = 0x03E0F827
    step();
    check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    check("bp_stable_A", instr, 32'h00221824);
    check("bp_stable_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_B_head", instr, 32'h00853025);
    step();
    check("bp_C_head", instr, 32'h03E0F827);
    step();
    check("bp_empty", {31'd0, instr_valid}, 32'd0);

    // Unsupported select 3'b011
    drive_req(3'b011, 5'd1, 5'd1, 5'd1, 5'd1);
    step();
    req_valid = 1'b0;
    check("unsup_no_valid", {31'd0, instr_valid}, 32'd0);
    check("unsup_pulse", {31'd0, err_pulse}, 32'd1);
    check("unsup_count1", {24'd0, err_count}, 32'd1);
    step();
    check("unsup_pulse_drop", {31'd0, err_pulse}, 32'd0);
    drive_req(3'b011, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 255; i++) step();
    req_valid = 1'b0;
    check("unsup_saturate", {24'd0, err_count}, 32'd255);
    check("unsup_fifo_empty", {31'd0, instr_valid}, 32'd0);
    step();

    // Round trip for every supported select
    instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_req(sels[i], 5'd1, 5'd2, 5'd3, 5'd4);
      step();
      check($sformatf("rt_sel%0d", i), {29'd0, decode_funct(instr[5:0])}, {29'd0, sels[i]});
    end
    req_valid = 1'b0;
    step();

    // Asynchronous reset with the FIFO full
    instr_ready = 1'b0;
    drive_req(3'b010, 5'd1, 5'd2, 5'd3, 5'd0);
    step();
    drive_req(3'b100, 5'd2, 5'd3, 5'd4, 5'd0);
    step();
    req_valid = 1'b0;
    check("full_before_rst", {31'd0, req_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_count", {24'd0, err_count}, 32'd0);
    check("arst_instr", instr, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("arst_no_residue", {31'd0, instr_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
